// File: rtl/cpu_microcode_pkg.sv
// Shared definitions for the microcode decoder: control FSM state codes, jump opcodes,
// MOV memory-operand patterns and the registered control word layout.
package cpu_microcode_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int STATE_W_DEF = 4;

    typedef enum logic [3:0] {
        STATE_FETCH_PC   = 4'h0,
        STATE_FETCH_INST = 4'h1,
        STATE_LDI        = 4'h2,
        STATE_MOV_FETCH  = 4'h3,
        STATE_MOV_LOAD   = 4'h4,
        STATE_MOV_STORE  = 4'h5,
        STATE_ALU_OP     = 4'h6,
        STATE_JUMP       = 4'h7,
        STATE_OUT_A      = 4'h8,
        STATE_NEXT       = 4'h9,
        STATE_HALT       = 4'hA
    } state_t;

    localparam logic [7:0] OP_JMP = 8'hC3;
    localparam logic [7:0] OP_JEZ = 8'hCA;
    localparam logic [7:0] OP_JNZ = 8'hC2;

    // Register code 7 in either MOV field selects the memory operand
    localparam logic [5:0] MOV_MEM_LOAD  = 6'o07;
    localparam logic [5:0] MOV_MEM_STORE = 6'o70;

    typedef struct packed {
        logic       pc_inc;
        logic       pc_load;
        logic       mar_load;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_load;
        logic       reg_rd_en;
        logic       reg_wr_en;
        logic [2:0] reg_rd_sel;
        logic [2:0] reg_wr_sel;
        logic       alu_en;
        logic [2:0] alu_op;
        logic       reset_cycle;
    } ctrl_t;

    function automatic logic is_legal_state(input logic [3:0] code);
        return code <= STATE_HALT;
    endfunction

endpackage

// File: rtl/cpu_microcode_if.sv
// Bus between the control FSM / datapath (master) and the microcode decoder (slave).
interface cpu_microcode_if #(
    parameter int DATA_W  = 8,
    parameter int STATE_W = 4
);
    logic [STATE_W-1:0] state;
    logic [7:0]         opcode;
    logic               alu_zero;
    logic [DATA_W-1:0]  a_value;
    logic               out_ready;

    logic               pc_inc;
    logic               pc_load;
    logic               mar_load;
    logic               mem_rd;
    logic               mem_wr;
    logic               ir_load;
    logic               reg_rd_en;
    logic               reg_wr_en;
    logic [2:0]         reg_rd_sel;
    logic [2:0]         reg_wr_sel;
    logic               alu_en;
    logic [2:0]         alu_op;
    logic               reset_cycle;
    logic               halted;
    logic               out_valid;
    logic [DATA_W-1:0]  out_data;
    logic               out_overrun;
    logic               illegal;

    modport slave (
        input  state, opcode, alu_zero, a_value, out_ready,
        output pc_inc, pc_load, mar_load, mem_rd, mem_wr, ir_load,
               reg_rd_en, reg_wr_en, reg_rd_sel, reg_wr_sel, alu_en, alu_op,
               reset_cycle, halted, out_valid, out_data, out_overrun, illegal
    );

    modport master (
        output state, opcode, alu_zero, a_value, out_ready,
        input  pc_inc, pc_load, mar_load, mem_rd, mem_wr, ir_load,
               reg_rd_en, reg_wr_en, reg_rd_sel, reg_wr_sel, alu_en, alu_op,
               reset_cycle, halted, out_valid, out_data, out_overrun, illegal
    );
endinterface

// File: rtl/cpu_microcode_out_port.sv
// Output-port latch: holds the last OUT value, runs the valid/ready handshake and
// flags an overrun when a new value replaces one the sink has not yet taken.
module cpu_out_port #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              overrun
);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid   <= 1'b0;
            data    <= '0;
            overrun <= 1'b0;
        end else begin
            if (load) begin
                data  <= load_data;
                valid <= 1'b1;
                // Accepting on the same edge frees the slot, so that case is not an overrun
                if (valid && !ready) begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cpu_microcode.sv
// Microcode decoder: registers the control word for (state, opcode), keeps the zero flag,
// halt latch and output port. Optional macro TRAP_ON_ILLEGAL_EN traps undefined state codes.
module cpu_microcode
    import cpu_microcode_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int STATE_W = STATE_W_DEF
) (
    input logic            clk,
    input logic            reset,
    cpu_microcode_if.slave bus
);

    logic [STATE_W-1:0] state_code;
    ctrl_t              ctrl_d;
    ctrl_t              ctrl_q;
    logic               zero_q;
    logic               halted_q;
    logic               jump_taken;
    logic               trap;
    logic               out_load;

    assign state_code = bus.state;

    always_comb begin
        jump_taken = 1'b0;
        case (bus.opcode)
            OP_JMP:  jump_taken = 1'b1;
            OP_JEZ:  jump_taken = zero_q;
            OP_JNZ:  jump_taken = !zero_q;
            default: jump_taken = 1'b0;
        endcase
    end

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        ctrl_d = '0;
        case (state_code)
            STATE_FETCH_PC: ctrl_d.mar_load = 1'b1;
            STATE_FETCH_INST: begin
                ctrl_d.mem_rd  = 1'b1;
                ctrl_d.ir_load = 1'b1;
                ctrl_d.pc_inc  = 1'b1;
            end
            STATE_LDI: begin
                ctrl_d.mem_rd     = 1'b1;
                ctrl_d.reg_wr_en  = 1'b1;
                ctrl_d.reg_wr_sel = bus.opcode[2:0];
                ctrl_d.pc_inc     = 1'b1;
            end
            STATE_MOV_FETCH: begin
                ctrl_d.mar_load = (bus.opcode[5:0] == MOV_MEM_LOAD) ||
                                  (bus.opcode[5:0] == MOV_MEM_STORE);
            end
            STATE_MOV_LOAD: begin
                ctrl_d.reg_rd_en  = 1'b1;
                ctrl_d.reg_rd_sel = bus.opcode[2:0];
            end
            STATE_MOV_STORE: begin
                ctrl_d.reg_wr_en  = 1'b1;
                ctrl_d.reg_wr_sel = bus.opcode[5:3];
            end
            STATE_ALU_OP: begin
                ctrl_d.alu_en = 1'b1;
                ctrl_d.alu_op = bus.opcode[2:0];
            end
            STATE_JUMP: begin
                ctrl_d.mem_rd  = 1'b1;
                ctrl_d.pc_load = jump_taken;
                ctrl_d.pc_inc  = !jump_taken;
            end
            STATE_NEXT: ctrl_d.reset_cycle = 1'b1;
            default: ctrl_d = '0;
        endcase
        if (halted_q) begin
            ctrl_d = '0;
        end
    end

`ifdef TRAP_ON_ILLEGAL_EN
    logic illegal_q;

    assign trap = !halted_q && !is_legal_state(state_code);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else if (trap) begin
            illegal_q <= 1'b1;
        end
    end

    assign bus.illegal = illegal_q;
`else
    assign trap        = 1'b0;
    assign bus.illegal = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q   <= '0;
            zero_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            if (!halted_q && state_code == STATE_ALU_OP) begin
                zero_q <= bus.alu_zero;
            end
            if (!halted_q && (state_code == STATE_HALT || trap)) begin
                halted_q <= 1'b1;
            end
        end
    end

    // Halt freezes new OUT instructions, but a pending value can still be drained
    assign out_load = !halted_q && state_code == STATE_OUT_A;

    cpu_out_port #(.DATA_W(DATA_W)) u_out_port (
        .clk      (clk),
        .reset    (reset),
        .load     (out_load),
        .load_data(bus.a_value),
        .ready    (bus.out_ready),
        .valid    (bus.out_valid),
        .data     (bus.out_data),
        .overrun  (bus.out_overrun)
    );

    assign bus.pc_inc      = ctrl_q.pc_inc;
    assign bus.pc_load     = ctrl_q.pc_load;
    assign bus.mar_load    = ctrl_q.mar_load;
    assign bus.mem_rd      = ctrl_q.mem_rd;
    assign bus.mem_wr      = ctrl_q.mem_wr;
    assign bus.ir_load     = ctrl_q.ir_load;
    assign bus.reg_rd_en   = ctrl_q.reg_rd_en;
    assign bus.reg_wr_en   = ctrl_q.reg_wr_en;
    assign bus.reg_rd_sel  = ctrl_q.reg_rd_sel;
    assign bus.reg_wr_sel  = ctrl_q.reg_wr_sel;
    assign bus.alu_en      = ctrl_q.alu_en;
    assign bus.alu_op      = ctrl_q.alu_op;
    assign bus.reset_cycle = ctrl_q.reset_cycle;
    assign bus.halted      = halted_q;

endmodule

// File: tb/tb_cpu_microcode.sv
// Bench for cpu_microcode: a vector table through a scoreboard queue, then hand-written
// sequences for async reset, the output handshake and halt.
module tb_cpu_microcode;
    import cpu_microcode_pkg::*;

    localparam logic [7:0] S_PCI = 8'h80, S_PCL = 8'h40, S_MAR = 8'h20, S_RD  = 8'h10;
    localparam logic [7:0] S_WR  = 8'h08, S_IR  = 8'h04, S_RRD = 8'h02, S_RWR = 8'h01;

    typedef struct packed {
        logic [7:0] strobes;   // pc_inc pc_load mar_load mem_rd mem_wr ir_load reg_rd_en reg_wr_en
        logic [2:0] rd_sel;
        logic [2:0] wr_sel;
        logic       alu_en;
        logic [2:0] alu_op;
        logic       reset_cycle;
        logic       halted;
        logic       out_valid;
        logic [7:0] out_data;
        logic       out_overrun;
        logic       illegal;
    } obs_t;

    typedef struct {
        string      name;
        logic [3:0] state;
        logic [7:0] opcode;
        logic       alu_zero;
        logic [7:0] a_value;
        logic       out_ready;
        obs_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_miss = 0;
    vec_t vecs[$];
    obs_t sb_exp[$];
    string sb_name[$];

    cpu_microcode_if #(.DATA_W(8), .STATE_W(4)) bus ();

    cpu_microcode dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic obs_t sample();
        obs_t o;
        o.strobes     = {bus.pc_inc, bus.pc_load, bus.mar_load, bus.mem_rd,
                         bus.mem_wr, bus.ir_load, bus.reg_rd_en, bus.reg_wr_en};
        o.rd_sel      = bus.reg_rd_sel;
        o.wr_sel      = bus.reg_wr_sel;
        o.alu_en      = bus.alu_en;
        o.alu_op      = bus.alu_op;
        o.reset_cycle = bus.reset_cycle;
        o.halted      = bus.halted;
        o.out_valid   = bus.out_valid;
        o.out_data    = bus.out_data;
        o.out_overrun = bus.out_overrun;
        o.illegal     = bus.illegal;
        return o;
    endfunction

    function automatic obs_t ex(input logic [7:0] s, input logic [2:0] rd, input logic [2:0] wr,
                                input logic ae, input logic [2:0] ao, input logic rc,
                                input logic h, input logic ov, input logic [7:0] od,
                                input logic oo);
        obs_t o;
        o = '{strobes: s, rd_sel: rd, wr_sel: wr, alu_en: ae, alu_op: ao, reset_cycle: rc,
              halted: h, out_valid: ov, out_data: od, out_overrun: oo, illegal: 1'b0};
        return o;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic add(input string n, input logic [3:0] st, input logic [7:0] op,
                       input logic z, input logic [7:0] a, input logic rdy, input obs_t e);
        vec_t v;
        v = '{name: n, state: st, opcode: op, alu_zero: z, a_value: a, out_ready: rdy, exp: e};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [3:0] st, input logic [7:0] op, input logic z,
                         input logic [7:0] a, input logic rdy);
        bus.state     = st;
        bus.opcode    = op;
        bus.alu_zero  = z;
        bus.a_value   = a;
        bus.out_ready = rdy;
    endtask

    // Drive on the falling edge, let the rising edge register it, compare 1 time unit later
    task automatic step(input vec_t v);
        @(negedge clk);
        drive(v.state, v.opcode, v.alu_zero, v.a_value, v.out_ready);
        sb_exp.push_back(v.exp);
        sb_name.push_back(v.name);
        @(posedge clk);
        #1;
        check(sb_name.pop_front(), sample(), sb_exp.pop_front());
    endtask

    task automatic run(input string n, input logic [3:0] st, input logic [7:0] op,
                       input logic z, input logic [7:0] a, input logic rdy, input obs_t e);
        vec_t v;
        v = '{name: n, state: st, opcode: op, alu_zero: z, a_value: a, out_ready: rdy, exp: e};
        step(v);
    endtask

    task automatic reset_pulse(input string name);
        @(negedge clk);
        reset = 1'b1;
        drive(4'h0, 8'h00, 1'b0, 8'h00, 1'b0);
        #1;
        check(name, sample(), '0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        obs_t e;
        drive(4'h0, 8'h00, 1'b0, 8'h00, 1'b0);

        add("fetch_pc",      STATE_FETCH_PC,   8'h00, 0, 8'h00, 0, ex(S_MAR, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
        add("fetch_inst",    STATE_FETCH_INST, 8'h00, 0, 8'h00, 0, ex(S_RD | S_IR | S_PCI, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
        add("ldi",           STATE_LDI,        8'h05, 0, 8'h00, 0, ex(S_RD | S_RWR | S_PCI, 0, 5, 0, 0, 0, 0, 0, 8'h00, 0));
        add("mov_fetch_ld",  STATE_MOV_FETCH,  8'h47, 0, 8'h00, 0, ex(S_MAR, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
        add("mov_fetch_st",  STATE_MOV_FETCH,  8'h78, 0, 8'h00, 0, ex(S_MAR, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
        add("mov_fetch_rr",  STATE_MOV_FETCH,  8'h4A, 0, 8'h00, 0, ex(8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
        add("mov_load",      STATE_MOV_LOAD,   8'h4A, 0, 8'h00, 0, ex(S_RRD, 2, 0, 0, 0, 0, 0, 0, 8'h00, 0));
        add("mov_store",     STATE_MOV_STORE,  8'h4A, 0, 8'h00, 0, ex(S_RWR, 0, 1, 0, 0, 0, 0, 0, 8'h00, 0));
        add("alu_nz",        STATE_ALU_OP,     8'h85, 0, 8'h00, 0, ex(8'h00, 0, 0, 1, 5, 0, 0, 0, 8'h00, 0));
        add("jez_z0",        STATE_JUMP,       OP_JEZ, 0, 8'h00, 0, ex(S_RD | S_PCI, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
        add("jnz_z0",        STATE_JUMP,       OP_JNZ, 0, 8'h00, 0, ex(S_RD | S_PCL, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
        add("jmp",           STATE_JUMP,       OP_JMP, 0, 8'h00, 0, ex(S_RD | S_PCL, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
        add("alu_z",         STATE_ALU_OP,     8'h82, 1, 8'h00, 0, ex(8'h00, 0, 0, 1, 2, 0, 0, 0, 8'h00, 0));
        add("fetch_keep_z",  STATE_FETCH_PC,   8'h00, 0, 8'h00, 0, ex(S_MAR, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
        add("jez_z1",        STATE_JUMP,       OP_JEZ, 0, 8'h00, 0, ex(S_RD | S_PCL, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
        add("jnz_z1",        STATE_JUMP,       OP_JNZ, 0, 8'h00, 0, ex(S_RD | S_PCI, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
        add("next",          STATE_NEXT,       8'h00, 0, 8'h00, 0, ex(8'h00, 0, 0, 0, 0, 1, 0, 0, 8'h00, 0));
        add("next_drop",     STATE_FETCH_PC,   8'h00, 0, 8'h00, 0, ex(S_MAR, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
        add("out_5a",        STATE_OUT_A,      8'h00, 0, 8'h5A, 0, ex(8'h00, 0, 0, 0, 0, 0, 0, 1, 8'h5A, 0));
        add("out_3c_ovr",    STATE_OUT_A,      8'h00, 0, 8'h3C, 0, ex(8'h00, 0, 0, 0, 0, 0, 0, 1, 8'h3C, 1));
        add("out_accept",    STATE_FETCH_PC,   8'h00, 0, 8'h00, 1, ex(S_MAR, 0, 0, 0, 0, 0, 0, 0, 8'h3C, 1));
        add("out_11",        STATE_OUT_A,      8'h00, 0, 8'h11, 0, ex(8'h00, 0, 0, 0, 0, 0, 0, 1, 8'h11, 1));
        add("out_22_accept", STATE_OUT_A,      8'h00, 0, 8'h22, 1, ex(8'h00, 0, 0, 0, 0, 0, 0, 1, 8'h22, 1));
        e = ex(8'h00, 0, 0, 0, 0, 0, 0, 1, 8'h22, 1);
`ifdef TRAP_ON_ILLEGAL_EN
        e.halted  = 1'b1;
        e.illegal = 1'b1;
`endif
        add("illegal_f",     4'hF,             8'h00, 0, 8'h00, 0, e);

        repeat (2) @(negedge clk);
        #1;
        check("reset_state", sample(), '0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) step(vecs[i]);

        // Async reset during a taken jump, with the zero flag set beforehand
        reset_pulse("reset_after_table");
        run("pre_alu_z", STATE_ALU_OP, 8'h80, 1, 8'h00, 0, ex(8'h00, 0, 0, 1, 0, 0, 0, 0, 8'h00, 0));
        run("pre_jmp",   STATE_JUMP,   OP_JMP, 0, 8'h00, 0, ex(S_RD | S_PCL, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", sample(), '0);
        @(posedge clk);
        #1;
        check("reset_hold", sample(), '0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("after_release", sample(), '0);
        run("jez_after_reset", STATE_JUMP, OP_JEZ, 0, 8'h00, 0, ex(S_RD | S_PCI, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));

        // Clean handshake without overrun, then reset discards pending data
        reset_pulse("reset_out");
        run("hs_out_5a",    STATE_OUT_A,    8'h00, 0, 8'h5A, 0, ex(8'h00, 0, 0, 0, 0, 0, 0, 1, 8'h5A, 0));
        run("hs_accept",    STATE_FETCH_PC, 8'h00, 0, 8'h00, 1, ex(S_MAR, 0, 0, 0, 0, 0, 0, 0, 8'h5A, 0));
        run("hs_out_77",    STATE_OUT_A,    8'h00, 0, 8'h77, 0, ex(8'h00, 0, 0, 0, 0, 0, 0, 1, 8'h77, 0));
        run("hs_out_88_acc", STATE_OUT_A,   8'h00, 0, 8'h88, 1, ex(8'h00, 0, 0, 0, 0, 0, 0, 1, 8'h88, 0));
        reset_pulse("reset_discard_out");

        // Halt blocks strobes and reset_cycle, the pending OUT still drains
        run("h_next",      STATE_NEXT,       8'h00, 0, 8'h00, 0, ex(8'h00, 0, 0, 0, 0, 1, 0, 0, 8'h00, 0));
        run("h_fetch",     STATE_FETCH_PC,   8'h00, 0, 8'h00, 0, ex(S_MAR, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
        run("h_out_99",    STATE_OUT_A,      8'h00, 0, 8'h99, 0, ex(8'h00, 0, 0, 0, 0, 0, 0, 1, 8'h99, 0));
        run("h_halt",      STATE_HALT,       8'h00, 0, 8'h00, 0, ex(8'h00, 0, 0, 0, 0, 0, 1, 1, 8'h99, 0));
        run("h_next_halt", STATE_NEXT,       8'h00, 0, 8'h00, 1, ex(8'h00, 0, 0, 0, 0, 0, 1, 0, 8'h99, 0));
        run("h_inst_halt", STATE_FETCH_INST, 8'h00, 0, 8'h00, 0, ex(8'h00, 0, 0, 0, 0, 0, 1, 0, 8'h99, 0));
        run("h_out_halt",  STATE_OUT_A,      8'h00, 0, 8'h55, 0, ex(8'h00, 0, 0, 0, 0, 0, 1, 0, 8'h99, 0));
        reset_pulse("reset_clear_halt");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
